// File: rtl/vga_text_pkg.sv
// Shared geometry, counter widths and address helper for the text-mode raster sequencer.
package vga_text_pkg;
  localparam int COLS       = 40;
  localparam int ROWS       = 24;
  localparam int CELL_W     = 16;
  localparam int CELL_H     = 20;
  localparam int VRAM_DEPTH = 960;

  localparam int PX_W   = 4;
  localparam int COL_W  = 6;
  localparam int LN_W   = 5;
  localparam int ROW_W  = 5;
  localparam int ADDR_W = 10;
  localparam int CHAR_W = 6;

  localparam logic [PX_W-1:0]   PX_LAST   = PX_W'(CELL_W - 1);
  localparam logic [COL_W-1:0]  COL_END   = COL_W'(COLS);
  localparam logic [LN_W-1:0]   LN_LAST   = LN_W'(CELL_H - 1);
  localparam logic [ROW_W-1:0]  ROW_END   = ROW_W'(ROWS);
  localparam logic [ROW_W-1:0]  MEM_LAST  = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] BASE_LAST = ADDR_W'((ROWS - 1) * COLS);

  // Shift-and-add keeps the multiply out of the sof path.
  function automatic logic [ADDR_W-1:0] row_times_40(input logic [ROW_W-1:0] t);
    logic [ADDR_W-1:0] tx;
    tx = ADDR_W'(t);
    return (tx << 5) + (tx << 3);
  endfunction
endpackage

// File: rtl/vga_text_sequencer_blink_timer.sv
// Frame counter that toggles the cursor blink phase every BLINK_FRAMES start-of-frame pulses.
module blink_timer #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic sof,
  output logic blink
);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] fcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt  <= '0;
      blink <= 1'b0;
    end else if (sof) begin
      if (fcnt == FCNT_LAST) begin
        fcnt  <= '0;
        blink <= ~blink;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/vga_text_sequencer.sv
// Walks the 40x24 character grid from raster strobes, reads video RAM, addresses the font ROM
// and delays sync/blank to line up with the registered font pixel.
module vga_text_sequencer
  import vga_text_pkg::*;
#(
  parameter int          BLINK_FRAMES = 30,
  parameter logic [5:0]  CURSOR_CHAR  = 6'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        active,
  input  logic        eol,
  input  logic        sof,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [4:0]  top_row,
  input  logic        cursor_en,
  input  logic [5:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  output logic [9:0]  vram_addr,
  output logic        vram_rd,
  input  logic [5:0]  vram_data,
  output logic [5:0]  font_char,
  output logic [3:0]  font_pixel,
  output logic [4:0]  font_line,
  input  logic        font_out,
  output logic        pixel_on,
  output logic        hsync_out,
  output logic        vsync_out
);
  logic [PX_W-1:0]   px;
  logic [COL_W-1:0]  col;
  logic [LN_W-1:0]   ln;
  logic [ROW_W-1:0]  row;
  logic [ROW_W-1:0]  mem_row;
  logic [ADDR_W-1:0] row_base;

  logic [ROW_W-1:0]  top_sel;
  logic              in_area;
  logic              blink;
  logic              hit;
  logic              hit_d1;
  logic [1:0]        area_sr;
  logic [1:0]        hs_sr;
  logic [1:0]        vs_sr;

  assign top_sel = (top_row > MEM_LAST) ? '0 : top_row;
  assign in_area = active && (col < COL_END) && (row < ROW_END);

  // Strobe priority sof > eol > active; a lower strobe never advances on the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      px       <= '0;
      col      <= '0;
      ln       <= '0;
      row      <= '0;
      mem_row  <= '0;
      row_base <= '0;
    end else if (sof) begin
      px       <= '0;
      col      <= '0;
      ln       <= '0;
      row      <= '0;
      mem_row  <= top_sel;
      row_base <= row_times_40(top_sel);
    end else if (eol) begin
      px  <= '0;
      col <= '0;
      if (ln == LN_LAST) begin
        ln <= '0;
        if (row != ROW_END) row <= row + 1'b1;
        mem_row  <= (mem_row == MEM_LAST) ? '0 : mem_row + 1'b1;
        row_base <= (row_base == BASE_LAST) ? '0 : row_base + ROW_STEP;
      end else begin
        ln <= ln + 1'b1;
      end
    end else if (active && (col < COL_END)) begin
      px <= px + 1'b1;
      if (px == PX_LAST) col <= col + 1'b1;
    end
  end

  assign vram_rd   = in_area && !rst;
  assign vram_addr = rst ? '0 : row_base + ADDR_W'(col);

  blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
    .clk   (clk),
    .rst   (rst),
    .sof   (sof),
    .blink (blink)
  );

  assign hit = cursor_en && blink && (col == cursor_col) && (mem_row == cursor_row);

  // Stage 1 follows the RAM read; stage 2 follows the font ROM register.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_d1     <= 1'b0;
      font_pixel <= '0;
      font_line  <= '0;
      area_sr    <= '0;
      hs_sr      <= '0;
      vs_sr      <= '0;
    end else begin
      hit_d1     <= hit;
      font_pixel <= px;
      font_line  <= ln;
      area_sr    <= {area_sr[0], in_area};
      hs_sr      <= {hs_sr[0], hsync_in};
      vs_sr      <= {vs_sr[0], vsync_in};
    end
  end

  assign font_char = area_sr[0] ? (hit_d1 ? CURSOR_CHAR : vram_data) : '0;
  assign pixel_on  = font_out && area_sr[1];
  assign hsync_out = hs_sr[1];
  assign vsync_out = vs_sr[1];
endmodule

// File: tb/tb_vga_text_sequencer.sv
// Randomized raster stimulus against a position-based reference model, plus directed literal pins.
module tb_vga_text_sequencer;
  localparam int         BF     = 2;
  localparam logic [5:0] CURSOR = 6'h00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       active = 1'b0, eol = 1'b0, sof = 1'b0;
  logic       hsync_in = 1'b0, vsync_in = 1'b0;
  logic [4:0] top_row = '0;
  logic       cursor_en = 1'b0;
  logic [5:0] cursor_col = '0;
  logic [4:0] cursor_row = '0;
  logic [9:0] vram_addr;
  logic       vram_rd;
  logic [5:0] vram_data;
  logic [5:0] font_char;
  logic [3:0] font_pixel;
  logic [4:0] font_line;
  logic       font_out;
  logic       pixel_on;
  logic       hsync_out, vsync_out;

  vga_text_sequencer #(.BLINK_FRAMES(BF), .CURSOR_CHAR(CURSOR)) dut (
    .clk(clk), .rst(rst), .active(active), .eol(eol), .sof(sof),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .top_row(top_row),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .vram_addr(vram_addr), .vram_rd(vram_rd), .vram_data(vram_data),
    .font_char(font_char), .font_pixel(font_pixel), .font_line(font_line),
    .font_out(font_out), .pixel_on(pixel_on),
    .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0] mem [0:1023];
  logic sync_rand = 1'b0;
  logic hs_v = 1'b0, vs_v = 1'b0;

  function automatic logic rom(input logic [5:0] c, input logic [3:0] p, input logic [4:0] l);
    logic [15:0] h;
    h = 16'(c) * 16'd37 + 16'(p) * 16'd11 + 16'(l) * 16'd3 + 16'(c) * 16'(p);
    return h[2];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // External video RAM and font ROM, each with one cycle of registered read latency.
  always @(posedge clk) begin
    vram_data <= vram_rd ? mem[vram_addr] : 6'($urandom_range(0, 63));
    font_out  <= rom(font_char, font_pixel, font_line);
  end

  // Reference model: position is "active pixels since eol" and "eols since sof".
  typedef struct {
    logic       area;
    logic [3:0] px;
    logic [4:0] ln;
    logic       hit;
    logic [9:0] addr;
    logic       hs;
    logic       vs;
    logic       rs;
  } hist_t;

  int    mx = 0, my = 0, mtop = 0, msofs = 0;
  logic  started = 1'b0;
  hist_t h1, h2, zero_h;

  initial begin
    zero_h = '{area: 1'b0, px: 4'd0, ln: 5'd0, hit: 1'b0, addr: 10'd0, hs: 1'b0, vs: 1'b0, rs: 1'b0};
    h1 = zero_h;
    h2 = zero_h;
  end

  always @(negedge clk) begin
    int col, px, ln, row, mrow, addr;
    logic area, blink, hit;
    logic [5:0] c1, c2;
    col   = mx / 16;
    px    = mx % 16;
    ln    = my % 20;
    row   = (my / 20 > 24) ? 24 : my / 20;
    mrow  = (mtop + my / 20) % 24;
    addr  = mrow * 40 + col;
    area  = active && !rst && (mx < 640) && (row < 24);
    blink = ((msofs / BF) % 2) == 1;
    hit   = cursor_en && blink && (col == int'(cursor_col)) && (mrow == int'(cursor_row));
    if (started) begin
      check("vram_rd", 32'(vram_rd), 32'(area));
      if (area) check("vram_addr", 32'(vram_addr), 32'(addr));
      if (rst) check("vram_addr_rst", 32'(vram_addr), 32'd0);
      check("font_pixel", 32'(font_pixel), 32'(h1.px));
      check("font_line", 32'(font_line), 32'(h1.ln));
      c1 = h1.hit ? CURSOR : mem[h1.addr];
      if (h1.area) check("font_char", 32'(font_char), 32'(c1));
      else if (h1.rs) check("font_char_rst", 32'(font_char), 32'd0);
      c2 = h2.hit ? CURSOR : mem[h2.addr];
      check("pixel_on", 32'(pixel_on), 32'(h2.area && rom(c2, h2.px, h2.ln)));
      check("hsync_out", 32'(hsync_out), 32'(h2.hs));
      check("vsync_out", 32'(vsync_out), 32'(h2.vs));
    end
    if (rst) begin
      started = 1'b1;
      mx = 0; my = 0; mtop = 0; msofs = 0;
      h2 = zero_h;
      h1 = zero_h;
      h1.rs = 1'b1;
    end else begin
      h2 = h1;
      h1 = '{area: area, px: 4'(px), ln: 5'(ln), hit: hit, addr: 10'(addr),
             hs: hsync_in, vs: vsync_in, rs: 1'b0};
      if (sof) begin
        msofs++;
        mtop = (top_row > 5'd23) ? 0 : int'(top_row);
        mx = 0; my = 0;
      end else if (eol) begin
        mx = 0; my++;
      end else if (active && mx < 640) begin
        mx++;
      end
    end
  end

  task automatic cyc(input logic r, input logic a, input logic e, input logic s);
    @(posedge clk);
    #1;
    rst = r; active = a; eol = e; sof = s;
    if (sync_rand) begin
      hsync_in = 1'($urandom_range(0, 1));
      vsync_in = 1'($urandom_range(0, 1));
    end else begin
      hsync_in = hs_v;
      vsync_in = vs_v;
    end
    @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nl, len;
    for (int i = 0; i < 1024; i++) mem[i] = 6'($urandom_range(0, 63));
    mem[85] = 6'h2A;

    repeat (4) cyc(1, 1, 0, 0);
    check("rst_vram_rd", 32'(vram_rd), 32'd0);
    check("rst_pixel_on", 32'(pixel_on), 32'd0);

    // First line from (0,0)
    cyc(0, 0, 0, 1);
    for (int k = 0; k < 17; k++) begin
      cyc(0, 1, 0, 0);
      if (k == 0)  check("pin_addr0", 32'(vram_addr), 32'd0);
      if (k == 2)  check("pin_fpix1", 32'(font_pixel), 32'd1);
      if (k == 16) check("pin_addr1", 32'(vram_addr), 32'd1);
    end

    // Sync delay of exactly two cycles
    hs_v = 1'b1; vs_v = 1'b0; cyc(0, 0, 0, 0);
    hs_v = 1'b0; vs_v = 1'b1; cyc(0, 0, 0, 0);
    vs_v = 1'b0;
    cyc(0, 0, 0, 0);
    check("pin_hsync_d2", 32'(hsync_out), 32'd1);
    cyc(0, 0, 0, 0);
    check("pin_hsync_d3", 32'(hsync_out), 32'd0);
    check("pin_vsync_d2", 32'(vsync_out), 32'd1);

    // Scroll: row 0 reads from memory row 23, then wraps to row 0
    top_row = 5'd23;
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 0);
    check("pin_scroll920", 32'(vram_addr), 32'd920);
    top_row = 5'd5;
    repeat (19) cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    check("pin_line19", 32'(font_line), 32'd19);
    check("pin_wrap0", 32'(vram_addr), 32'd0);
    cyc(0, 1, 0, 0);
    check("pin_line0", 32'(font_line), 32'd0);

    // Simultaneous strobes: sof wins
    cyc(0, 1, 1, 1);
    cyc(0, 1, 0, 0);
    check("pin_prio", 32'(vram_addr), 32'd200);

    // Overrun past column 40
    cyc(0, 0, 0, 1);
    for (int k = 0; k < 700; k++) begin
      cyc(0, 1, 0, 0);
      if (k == 639) check("pin_addr239", 32'(vram_addr), 32'd239);
      if (k == 660) check("pin_overrun_rd", 32'(vram_rd), 32'd0);
      if (k == 660) check("pin_overrun_px", 32'(pixel_on), 32'd0);
    end

    // Row saturation after 480 lines
    top_row = 5'd0;
    cyc(0, 0, 0, 1);
    repeat (480) cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    check("pin_row24_rd", 32'(vram_rd), 32'd0);

    // Cursor at (5,2): sof #6 has blink=1, sof #8 has blink=0
    cursor_en = 1'b1; cursor_col = 6'd5; cursor_row = 5'd2;
    for (int f = 0; f < 3; f++) begin
      cyc(0, 0, 0, 1);
      if (f != 1) begin
        repeat (40) cyc(0, 0, 1, 0);
        for (int k = 0; k < 82; k++) begin
          cyc(0, 1, 0, 0);
          if (k == 80) check("pin_cursor_addr", 32'(vram_addr), 32'd85);
          if (k == 81) check("pin_cursor_char", 32'(font_char), (f == 0) ? 32'h00 : 32'h2A);
        end
      end
    end

    // Randomized frames
    sync_rand = 1'b1;
    for (int f = 0; f < 7; f++) begin
      top_row    = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
      cursor_en  = $urandom_range(0, 3) != 0;
      cursor_col = 6'($urandom_range(0, 4));
      cursor_row = 5'($urandom_range(0, 11));
      cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
      nl = (f == 2) ? 490 : $urandom_range(20, 240);
      for (int l = 0; l < nl; l++) begin
        len = (f == 2) ? $urandom_range(0, 3)
            : (($urandom_range(0, 39) == 0) ? $urandom_range(600, 700) : $urandom_range(0, 60));
        for (int k = 0; k < len; k++) begin
          if ($urandom_range(0, 999) == 0) top_row = 5'($urandom_range(0, 31));
          cyc(0, $urandom_range(0, 7) != 0, $urandom_range(0, 499) == 0, 0);
        end
        cyc(0, 1'($urandom_range(0, 1)), 1, 0);
        repeat ($urandom_range(0, 2)) cyc(0, 0, 0, 0);
        if (f == 3 && l == nl / 2) begin
          repeat (3) cyc(1, 1, 0, 0);
          cyc(0, 1, 0, 0);
          check("pin_midreset_addr", 32'(vram_addr), 32'd0);
          check("pin_midreset_rd", 32'(vram_rd), 32'd1);
        end
      end
    end

    repeat (4) cyc(0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_text_sequencer.md
# vga_text_sequencer

Raster-side controller that feeds the terminal's font ROM. From the VGA timing generator's active/line/frame strobes it walks the 40×24 character grid (16×20-pixel cells) and issues video-RAM reads. It drives the font ROM's character, pixel and line inputs, applies hardware scroll and a blinking cursor, and delays sync and blank so they align with the font ROM's registered pixel.

## Interface
- `BLINK_FRAMES`, 30: frames per cursor blink half-period (≥1).
- `CURSOR_CHAR`, 6'h00: glyph substituted at the cursor cell ('@').
---
- `clk`  in  1  pixel clock (25 MHz); one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `active`  in  1  current pixel is in the visible area.
- `eol`  in  1  one-cycle pulse after the last visible pixel of a line.
- `sof`  in  1  one-cycle start-of-frame pulse, issued during vertical blank.
- `hsync_in`, `vsync_in`  in  1 each  raw syncs from the timing generator.
- `top_row`  in  5  memory row shown at screen row 0 (0..23); sampled on `sof`.
- `cursor_en`  in  1  enable the cursor overlay.
- `cursor_col`  in  6  cursor column (0..39).
- `cursor_row`  in  5  cursor memory row (0..23).
- `vram_addr`  out  10  video-RAM address, row·40+col.
- `vram_rd`  out  1  read strobe for `vram_addr`.
- `vram_data`  in  6  character code, valid one cycle after `vram_rd`.
- `font_char`  out  6  font ROM character.
- `font_pixel`  out  4  font ROM pixel column.
- `font_line`  out  5  font ROM line.
- `font_out`  in  1  font ROM pixel, registered, one cycle after the address.
- `pixel_on`  out  1  final pixel (`font_out` & aligned active).
- `hsync_out`, `vsync_out`  out  1 each  syncs delayed 2 cycles.

## Operation
- **Counters:** `px` 0..15, `col` 0..40, `ln` 0..19, `row` 0..24, `mem_row` 0..23, `row_base` 0..920 (step 40).
- **Active cycle with `col`<40:** `px`++. When `px` wraps 15→0, `col`++. `col`=40 is the out-of-area state and holds there.
- **`eol`:** `px`,`col`←0. `ln`++. When `ln` wraps 19→0: `row`++ (saturates at 24), `mem_row` wraps 23→0, and `row_base` +=40 with 920→0.
- **`sof`:** `px`,`col`,`ln`,`row`←0. `mem_row`←`top_row`. `row_base`←`top_row`·40, computed as (t<<5)+(t<<3). `top_row` is ignored mid-frame. A `top_row`>23 is treated as 0.
- **Priority:** `sof` > `eol` > `active`. Counters do not advance on a cycle where a higher-priority strobe fires.
- **In area:** `active`=1 ∧ `col`<40 ∧ `row`<24. `vram_rd` is asserted only when in area. `vram_addr` = `row_base`+`col`, combinational from the counters. Outside the area it is a don't-care.
- **Blink:** `fcnt` increments on `sof`. At `BLINK_FRAMES`−1 it wraps to 0 and toggles `blink`.
- **Cursor hit:** `cursor_en` ∧ `blink` ∧ `col`==`cursor_col` ∧ `mem_row`==`cursor_row`. The hit flag is registered alongside the stage-1 registers.
- **Font address:** `font_char` = hit ? `CURSOR_CHAR` : `vram_data`. `font_pixel` and `font_line` are `px` and `ln` registered by one cycle.

## Timing
- **t:** counters present; `vram_addr` and `vram_rd` are valid.
- **t+1:** `vram_data` arrives. `font_char`, `font_pixel` and `font_line` are valid, together with stage-1 area and hit flags.
- **t+2:** `font_out` is valid. `pixel_on` = `font_out` ∧ area_d2, with area_d2 being the in-area flag delayed 2 cycles. `hsync_out`/`vsync_out` equal `hsync_in`/`vsync_in` from t.
- **Latency:** 2 cycles from input to pixel, with sustained throughput of 1 pixel/cycle.
- **Reset:** all counters and `fcnt`←0, `blink`←0, `mem_row`,`row_base`←0, all pipeline flags←0. Output values during reset:
  - `vram_rd`=0, `vram_addr`=0, `pixel_on`=0.
  - `font_char`=0, `font_pixel`=0, `font_line`=0.
  - `hsync_out`=0, `vsync_out`=0.
- **Reset mid-line:** the next pixels are indexed from (0,0) until the next `sof`.

## Structure
- **Package `vga_text_pkg`:**
  - COLS=40, ROWS=24, CELL_W=16, CELL_H=20, VRAM_DEPTH=960.
  - Counter widths.
  - `row_times_40` function.
- **Sub-module `blink_timer`:** holds `fcnt` and `blink`. Inputs are `clk`, `rst` and `sof`. Parameterised by `BLINK_FRAMES`.
- The 2-stage sync/area delay is inline shift registers in the top level.

## Test plan
- **Reset then first pixel:** `sof`, then `active` for 640 cycles. Expect `vram_addr` 0 for 16 cycles, then 1, …, 39. `font_pixel` cycles 0..15, delayed one cycle. `pixel_on` is 0 for the first 2 cycles.
- **Row wrap:** pulse `eol` 20 times. Expect `font_line` to go 19→0 and `vram_addr` to jump to 40. After 480 lines, `row`=24 and `vram_rd` stays 0.
- **Scroll:** `top_row`=23 at `sof`. Expect screen row 0 to read addresses 920..959 and screen row 1 to read 0..39. Changing `top_row` mid-frame has no effect.
- **Cursor:** `cursor_en`=1, (col 5, row 2), `BLINK_FRAMES`=2. Expect `font_char`=0x00 at address 85 only on frames where `blink`=1, with `blink` toggling every 2 `sof`.
- **Overrun:** hold `active` for 700 cycles. Expect `col` to stick at 40, `vram_rd`=0 and `pixel_on`=0 for cycles ≥640+2.
- **Priority:** assert `sof`, `eol` and `active` in the same cycle. Expect the counters zeroed with no increment. Check that `hsync_out` equals `hsync_in` delayed exactly 2 cycles.
